// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
//   Shared constants and helper functions for the 4-digit seven-segment display
//   path.
//
//   Segment bit order: {g,f,e,d,c,b,a}, so bit 0 is segment a.
//   All segment patterns are active low: 0 lights the segment.
// -----------------------------------------------------------------------------
package disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = $clog2(NUM_DIGITS);
  localparam int WORD_W     = 4 * NUM_DIGITS;

  // Active-low segment patterns, {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // True when any nibble of the packed word is not a legal BCD digit.
  function automatic logic bcd_word_invalid(input logic [WORD_W-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Index of the most-significant nonzero nibble; 0 when the word is all zero,
  // so the ones digit always remains visible.
  function automatic logic [SEL_W-1:0] msd_index(input logic [WORD_W-1:0] w);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w[4*i +: 4] != 4'd0) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
//   Combinational BCD nibble to active-low seven-segment pattern.
//   Nibbles 0-9 map to their digit; A-F show a dash.
//
//   Ports
//     nibble  in  4  digit value
//     seg_n   out 7  {g,f,e,d,c,b,a}, active low
// -----------------------------------------------------------------------------
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    // NOTE: a default assignment ahead of the case keeps this purely combinational (no latch).
    seg_n = SEG_DASH;
    case (nibble)
      4'd0: seg_n = SEG_0;
      4'd1: seg_n = SEG_1;
      4'd2: seg_n = SEG_2;
      4'd3: seg_n = SEG_3;
      4'd4: seg_n = SEG_4;
      4'd5: seg_n = SEG_5;
      4'd6: seg_n = SEG_6;
      4'd7: seg_n = SEG_7;
      4'd8: seg_n = SEG_8;
      4'd9: seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// -----------------------------------------------------------------------------
// bcd_7seg_scan
//   Latches a packed 4-digit BCD word and drives a time-multiplexed common-anode
//   seven-segment display.
//
//   Each refresh tick (every CLK_HZ/REFRESH_HZ clocks) advances the scan by one
//   digit. All outputs are registered. The anode and segment outputs follow
//   disp_reg, digit_sel and blank with one clock of latency.
//
//   Ports
//     clk         in   1   system clock, rising edge
//     rst         in   1   synchronous, active-high reset
//     bcd         in   16  packed BCD, [15:12]=thousands ... [3:0]=ones
//     bcd_valid   in   1   load strobe; bcd is captured on the same edge
//     blank       in   1   forces all anodes off; scanning keeps running
//     an          out  4   anode enables, active low, an[0] = ones digit
//     seg         out  7   {g,f,e,d,c,b,a}, active low
//     dp          out  1   decimal point, active low, always off
//     bcd_err     out  1   latched word contains a nibble greater than 9
//     frame_done  out  1   one-cycle pulse after the scan wraps from digit 3 to 0
//
//   Build option
//     LEADING_ZERO_BLANK_EN  turns off digits above the most-significant
//                            nonzero digit. Digit 0 is always shown.
// -----------------------------------------------------------------------------
module bcd_7seg_scan
  import disp_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_W-1:0]     bcd,
  input  logic                  bcd_valid,
  input  logic                  blank,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  bcd_err,
  output logic                  frame_done
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  logic [PW-1:0]         prescaler_q,  prescaler_d;
  logic [SEL_W-1:0]      digit_sel_q,  digit_sel_d;
  logic [WORD_W-1:0]     disp_reg_q,   disp_reg_d;
  logic [NUM_DIGITS-1:0] an_q,         an_d;
  logic [6:0]            seg_q,        seg_d;
  logic                  dp_q,         dp_d;
  logic                  bcd_err_q,    bcd_err_d;
  logic                  frame_done_q, frame_done_d;

  logic       tick;
  logic       digit_lit;
  logic [3:0] cur_nibble;
  logic [6:0] cur_pattern;

  // The digit mux comes first, so a single decoder serves all four digits.
  assign cur_nibble = disp_reg_q[{digit_sel_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble (cur_nibble),
    .seg_n  (cur_pattern)
  );

  always_comb begin
    tick         = (prescaler_q == PW'(DIV - 1));
    prescaler_d  = tick ? '0 : prescaler_q + PW'(1);
    // The 2-bit select wraps 3 -> 0 on its own.
    digit_sel_d  = tick ? digit_sel_q + SEL_W'(1) : digit_sel_q;
    frame_done_d = tick && (digit_sel_q == SEL_W'(NUM_DIGITS - 1));

    disp_reg_d = disp_reg_q;
    bcd_err_d  = bcd_err_q;
    if (bcd_valid) begin
      disp_reg_d = bcd;
      bcd_err_d  = bcd_word_invalid(bcd);
    end

`ifdef LEADING_ZERO_BLANK_EN
    digit_lit = !blank && (digit_sel_q <= msd_index(disp_reg_q));
`else
    digit_lit = !blank;
`endif

    an_d  = digit_lit ? ~(NUM_DIGITS'(1) << digit_sel_q) : {NUM_DIGITS{1'b1}};
    seg_d = cur_pattern;
    dp_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample its pre-edge input, whatever the statement order.
    if (rst) begin
      prescaler_q  <= '0;
      digit_sel_q  <= '0;
      disp_reg_q   <= '0;
      an_q         <= {NUM_DIGITS{1'b1}};
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      bcd_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      digit_sel_q  <= digit_sel_d;
      disp_reg_q   <= disp_reg_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      bcd_err_q    <= bcd_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign bcd_err    = bcd_err_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_7seg_scan
//   Self-checking bench for bcd_7seg_scan with CLK_HZ=8 and REFRESH_HZ=2
//   (four clocks per digit).
//
//   The reference model tracks only the edge count since reset and the
//   latched word. The scan position is computed arithmetically from the
//   edge count.
// -----------------------------------------------------------------------------
module tb_bcd_7seg_scan;

  localparam int DIV    = 4;
  localparam int FRAME  = 4 * DIV;

  logic        clk;
  logic        rst;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic        blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        bcd_err;
  logic        frame_done;

  bcd_7seg_scan #(
    .CLK_HZ     (8),
    .REFRESH_HZ (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd        (bcd),
    .bcd_valid  (bcd_valid),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .bcd_err    (bcd_err),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec;
  int n_err;

  // Reference model state
  int          k;        // non-reset edges since the last reset
  logic [15:0] m_word;
  logic        m_err;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_fd;

  logic [6:0] seg_table [10];

  function automatic int nib(input logic [15:0] w, input int d);
    return int'((w >> (4 * d)) & 16'h000F);
  endfunction

  function automatic logic [6:0] ref_seg(input int n);
    if (n > 9) return 7'b0111111;
    return seg_table[n];
  endfunction

  function automatic logic ref_bad(input logic [15:0] w);
    for (int i = 0; i < 4; i++) if (nib(w, i) > 9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic ref_lit(input logic [15:0] w, input int d);
`ifdef LEADING_ZERO_BLANK_EN
    int msd;
    msd = 0;
    for (int i = 0; i < 4; i++) if (nib(w, i) != 0) msd = i;
    return d <= msd;
`else
    return (w == w) && (d >= 0);
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: inputs as currently driven are sampled at the edge. The model
  // advances, then the outputs are compared 1 time unit after the edge.
  task automatic step();
    logic        r, v, b;
    logic [15:0] w;
    int          d;
    r = rst; v = bcd_valid; b = blank; w = bcd;
    @(posedge clk);
    if (r) begin
      k = 0; m_word = 16'h0000; m_err = 1'b0;
      e_an = 4'b1111; e_seg = 7'b1111111; e_fd = 1'b0;
    end else begin
      d     = (k / DIV) % 4;
      e_an  = (b || !ref_lit(m_word, d)) ? 4'b1111 : ~(4'b0001 << d);
      e_seg = ref_seg(nib(m_word, d));
      e_fd  = ((k + 1) % FRAME) == 0;
      if (v) begin
        m_word = w;
        m_err  = ref_bad(w);
      end
      k++;
    end
    #1;
    check("an",         16'(an),         16'(e_an));
    check("seg",        16'(seg),        16'(e_seg));
    check("dp",         16'(dp),         16'(1'b1));
    check("bcd_err",    16'(bcd_err),    16'(m_err));
    check("frame_done", 16'(frame_done), 16'(e_fd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [15:0] w);
    bcd = w; bcd_valid = 1'b1;
    step();
    bcd_valid = 1'b0;
  endtask

  int fd_count;

  initial begin
    seg_table[0] = 7'b1000000; seg_table[1] = 7'b1111001;
    seg_table[2] = 7'b0100100; seg_table[3] = 7'b0110000;
    seg_table[4] = 7'b0011001; seg_table[5] = 7'b0010010;
    seg_table[6] = 7'b0000010; seg_table[7] = 7'b1111000;
    seg_table[8] = 7'b0000000; seg_table[9] = 7'b0010000;
    n_vec = 0; n_err = 0; k = 0; m_word = '0; m_err = 1'b0;

    // Reset held three clocks
    rst = 1'b1; bcd = 16'h0000; bcd_valid = 1'b0; blank = 1'b0;
    run(3);
    check("rst_an",  16'(an),  16'h000F);
    check("rst_seg", 16'(seg), 16'h007F);
    rst = 1'b0;
    step();
    check("rel_an", 16'(an), 16'h000E);
    run(12);

    // Frame of 1234, with frame_done counted over 32 clocks
    load(16'h1234);
    fd_count = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (frame_done) fd_count++;
    end
    check("fd_per_2frames", 16'(fd_count), 16'd2);

    // Invalid nibble, then recovery
    load(16'h12A4);
    check("err_set", 16'(bcd_err), 16'h0001);
    run(FRAME);
    load(16'h0005);
    check("err_clr", 16'(bcd_err), 16'h0000);
    run(6);

    // Blank mid-frame, then release
    blank = 1'b1;
    run(10);
    check("blank_an", 16'(an), 16'h000F);
    blank = 1'b0;
    run(10);

    // Load coincides with a refresh tick
    while ((k % DIV) != DIV - 1) step();
    load(16'h9999);
    step();
    check("tick_load_seg", 16'(seg), 16'h0010);

    // Leading-zero words
    load(16'h0042);
    run(FRAME + 2);
    load(16'h0000);
    run(FRAME + 2);

    // Reset mid-frame, held two clocks
    run(5);
    rst = 1'b1;
    step();
    check("midrst_an",  16'(an),         16'h000F);
    check("midrst_seg", 16'(seg),        16'h007F);
    check("midrst_fd",  16'(frame_done), 16'h0000);
    step();
    rst = 1'b0;
    run(6);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bcd_valid = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 2))
        0: bcd = 16'($urandom);
        1: bcd = 16'($urandom) & 16'h00FF;
        default: bcd = {4'd0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
      if ($urandom_range(0, 15) == 0) blank = ~blank;
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; blank = 1'b0; bcd_valid = 1'b0;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
